// File: rtl/acl_key_serializer_pkg.sv
// Shared types and helpers for the ACL lookup key serializer.
// Imported by the top and its saturating error counters.
package acl_key_serializer_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PAD     = 2'd2,
    ST_SKIP    = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int key_bytes(
    input int key_w,
    input int beat_w
  );
    return key_w / beat_w;
  endfunction

endpackage

// File: rtl/acl_key_serializer_sat_cnt16.sv
// 16-bit saturating event counter for the switch error registers.
// Clear wins over an increment in the same cycle.
module sat_cnt16
  import acl_key_serializer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [ERR_CNT_W-1:0] o_cnt
);

  logic [ERR_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/acl_key_serializer.sv
// Turns the head of each MAC frame into a fixed-length byte-serial
// TCAM lookup key, with one lookup outstanding at a time.
module acl_key_serializer
  import acl_key_serializer_pkg::*;
#(
  parameter  int LOOK_UP_DATA_WIDTH  = 280,
  parameter  int PORT_MNG_DATA_WIDTH = 8,
  parameter  int TIMEOUT_CYC         = 64,
  localparam int KEY_BYTES           =
    key_bytes(LOOK_UP_DATA_WIDTH, PORT_MNG_DATA_WIDTH),
  localparam int CNT_W               = clog2(KEY_BYTES)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [PORT_MNG_DATA_WIDTH-1:0] i_mac_data,
  input  logic                           i_mac_data_vld,
  input  logic                           i_mac_data_last,
  output logic [PORT_MNG_DATA_WIDTH-1:0] o_look_up_data,
  output logic                           o_look_up_data_vld,
  output logic [CNT_W-1:0]               o_look_up_data_cnt,
  input  logic                           i_acl_vld,
  input  logic                           i_switch_err_cnt_clr,
  output logic                           o_key_pending,
  output logic [ERR_CNT_W-1:0]           o_drop_cnt,
  output logic [ERR_CNT_W-1:0]           o_timeout_cnt
);

  localparam int TO_W =
    (clog2(TIMEOUT_CYC) > 0) ? clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(KEY_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYC - 1);

  state_e                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               r_out_cnt;
  logic [PORT_MNG_DATA_WIDTH-1:0] r_data;
  logic                           r_vld;
  logic                           r_pad_in;
  logic                           r_pending;
  logic [TO_W-1:0]                r_tmo;

  logic w_at_last;
  logic w_pad_in_nxt;
  logic w_drop;
  logic w_key_done;
  logic w_ack;
  logic w_tmo_hit;

  assign w_at_last = (r_cnt == LAST_IDX);

  // Whether a foreign frame is still mid-flight after this PAD cycle.
  assign w_pad_in_nxt = i_mac_data_vld ? !i_mac_data_last
                                       : r_pad_in;

  always_comb begin
    w_drop     = 1'b0;
    w_key_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_drop = i_mac_data_vld && r_pending;
      end
      ST_COLLECT: begin
        w_key_done = i_mac_data_vld && w_at_last;
      end
      ST_PAD: begin
        w_drop     = i_mac_data_vld && !r_pad_in;
        w_key_done = w_at_last;
      end
      default: begin
        w_drop     = 1'b0;
        w_key_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_out_cnt <= '0;
      r_data    <= '0;
      r_vld     <= 1'b0;
      r_pad_in  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_mac_data_vld) begin
            if (r_pending) begin
              r_state <= i_mac_data_last ? ST_IDLE
                                         : ST_SKIP;
            end else begin
              r_vld     <= 1'b1;
              r_data    <= i_mac_data;
              r_out_cnt <= '0;
              r_cnt     <= CNT_W'(1);
              r_state   <= i_mac_data_last ? ST_PAD
                                           : ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (i_mac_data_vld) begin
            r_vld     <= 1'b1;
            r_data    <= i_mac_data;
            r_out_cnt <= r_cnt;
            r_cnt     <= r_cnt + 1'b1;
            if (w_at_last) begin
              r_state <= i_mac_data_last ? ST_IDLE
                                         : ST_SKIP;
            end else if (i_mac_data_last) begin
              r_state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          r_vld     <= 1'b1;
          r_data    <= '0;
          r_out_cnt <= r_cnt;
          r_cnt     <= r_cnt + 1'b1;
          r_pad_in  <= w_pad_in_nxt;
          if (w_at_last) begin
            r_state  <= w_pad_in_nxt ? ST_SKIP : ST_IDLE;
            r_pad_in <= 1'b0;
          end
        end
        default: begin
          if (i_mac_data_vld && i_mac_data_last) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // A result strobe only counts while a key is outstanding.
  assign w_ack     = i_acl_vld && r_pending;
  assign w_tmo_hit = r_pending && !i_acl_vld &&
                     (r_tmo == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pending <= 1'b0;
      r_tmo     <= '0;
    end else if (w_key_done) begin
      r_pending <= 1'b1;
      r_tmo     <= '0;
    end else if (w_ack || w_tmo_hit) begin
      r_pending <= 1'b0;
      r_tmo     <= '0;
    end else if (r_pending) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  sat_cnt16 u_drop_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_switch_err_cnt_clr),
    .i_inc (w_drop),
    .o_cnt (o_drop_cnt)
  );

  sat_cnt16 u_timeout_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_switch_err_cnt_clr),
    .i_inc (w_tmo_hit),
    .o_cnt (o_timeout_cnt)
  );

  assign o_look_up_data     = r_data;
  assign o_look_up_data_vld = r_vld;
  assign o_look_up_data_cnt = r_out_cnt;
  assign o_key_pending      = r_pending;

endmodule

// File: tb/tb_acl_key_serializer.sv
// Bench for acl_key_serializer: directed scenarios plus random
// frames, checked each cycle against a frame-level reference model.
module tb_acl_key_serializer;

  localparam int KB = 35;
  localparam int TO = 64;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_mac_data = '0;
  logic        i_mac_data_vld = 1'b0;
  logic        i_mac_data_last = 1'b0;
  logic        i_acl_vld = 1'b0;
  logic        i_switch_err_cnt_clr = 1'b0;
  logic [7:0]  o_look_up_data;
  logic        o_look_up_data_vld;
  logic [5:0]  o_look_up_data_cnt;
  logic        o_key_pending;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_timeout_cnt;

  acl_key_serializer #(
    .LOOK_UP_DATA_WIDTH  (280),
    .PORT_MNG_DATA_WIDTH (8),
    .TIMEOUT_CYC         (TO)
  ) dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_mac_data           (i_mac_data),
    .i_mac_data_vld       (i_mac_data_vld),
    .i_mac_data_last      (i_mac_data_last),
    .o_look_up_data       (o_look_up_data),
    .o_look_up_data_vld   (o_look_up_data_vld),
    .o_look_up_data_cnt   (o_look_up_data_cnt),
    .i_acl_vld            (i_acl_vld),
    .i_switch_err_cnt_clr (i_switch_err_cnt_clr),
    .o_key_pending        (o_key_pending),
    .o_drop_cnt           (o_drop_cnt),
    .o_timeout_cnt        (o_timeout_cnt)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s got=%0h exp=%0h t=%0t",
                 tag, got, exp, $time);
    end
  endtask

  // Reference model, frame level: which frame owns the key,
  // how many key bytes are out, and how old the lookup is.
  bit         m_acc, m_own, m_src_done, m_in, m_pend;
  int         m_key_n, m_age;
  bit         e_vld;
  logic [7:0] e_data;
  int         e_cnt, e_drop, e_to;

  always @(posedge i_clk or negedge i_rst) begin : model
    bit acc0, pend0, start, drop, done, tmo, own_beat;
    if (!i_rst) begin
      m_acc = 0; m_own = 0; m_src_done = 0;
      m_in = 0; m_pend = 0; m_key_n = 0; m_age = 0;
      e_vld = 0; e_data = '0; e_cnt = 0;
      e_drop = 0; e_to = 0;
    end else begin
      acc0  = m_acc;
      pend0 = m_pend;
      drop  = 0;
      done  = 0;
      tmo   = 0;
      e_vld = 0;
      start = i_mac_data_vld && !m_in;
      if (start) begin
        if (acc0 || pend0) begin
          drop  = 1;
          m_own = 0;
        end else begin
          m_acc      = 1;
          m_own      = 1;
          m_src_done = 0;
          m_key_n    = 0;
        end
      end
      own_beat = i_mac_data_vld && m_own;
      if (m_acc && (m_src_done || own_beat)) begin
        e_vld  = 1;
        e_data = m_src_done ? 8'h00 : i_mac_data;
        e_cnt  = m_key_n;
        m_key_n++;
        if (m_key_n == KB) begin
          m_acc = 0;
          done  = 1;
        end
      end
      if (own_beat && i_mac_data_last) begin
        m_src_done = 1;
        m_own      = 0;
      end
      if (i_mac_data_vld) m_in = !i_mac_data_last;
      if (pend0) begin
        if (i_acl_vld) m_pend = 0;
        else if (m_age == TO - 1) begin
          m_pend = 0;
          tmo    = 1;
        end else m_age++;
      end
      if (done) begin
        m_pend = 1;
        m_age  = 0;
      end
      if (!m_pend) m_age = 0;
      if (i_switch_err_cnt_clr) begin
        e_drop = 0;
        e_to   = 0;
      end else begin
        if (drop && e_drop < 65535) e_drop++;
        if (tmo && e_to < 65535) e_to++;
      end
    end
  end

  int mon_beats = 0;

  always @(negedge i_clk) begin
    chk("vld", o_look_up_data_vld, e_vld);
    if (e_vld || !i_rst) begin
      chk("data", o_look_up_data, e_data);
      chk("cnt", o_look_up_data_cnt, e_cnt);
    end
    chk("pend", o_key_pending, m_pend);
    chk("drop", o_drop_cnt, e_drop);
    chk("tmo", o_timeout_cnt, e_to);
    if (o_look_up_data_vld) mon_beats++;
  end

  task automatic drive(
    input bit         v,
    input bit         l,
    input logic [7:0] d,
    input bit         ack,
    input bit         clr
  );
    i_mac_data           = d;
    i_mac_data_vld       = v;
    i_mac_data_last      = l;
    i_acl_vld            = ack;
    i_switch_err_cnt_clr = clr;
    @(posedge i_clk);
    #1;
    i_mac_data_vld       = 1'b0;
    i_mac_data_last      = 1'b0;
    i_acl_vld            = 1'b0;
    i_switch_err_cnt_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 8'h00, 0, 0);
  endtask

  task automatic frame(
    input int len,
    input int base,
    input int ack_at
  );
    for (int i = 0; i < len; i++)
      drive(1, i == len - 1, 8'(base + i), i == ack_at, 0);
  endtask

  initial begin
    int b0;
    int guard;
    #1 i_rst = 1'b0;
    idle(3);
    i_rst = 1'b1;
    idle(2);

    // 1: long frame, ack five cycles after the last key byte
    b0 = mon_beats;
    frame(64, 0, 39);
    idle(5);
    chk("t1_beats", mon_beats - b0, KB);
    chk("t1_pend", o_key_pending, 0);

    // 2: short frame is zero padded to the full key
    b0 = mon_beats;
    frame(20, 8'h40, -1);
    idle(20);
    chk("t2_beats", mon_beats - b0, KB);
    chk("t2_pend", o_key_pending, 1);

    // 3: drop while pending, then timeout, then normal frame
    drive(0, 0, 8'h00, 0, 1);
    b0 = mon_beats;
    frame(10, 8'h70, -1);
    idle(70);
    chk("t3_noemit", mon_beats - b0, 0);
    chk("t3_drop", o_drop_cnt, 1);
    chk("t3_tmo", o_timeout_cnt, 1);
    chk("t3_pend", o_key_pending, 0);
    b0 = mon_beats;
    frame(35, 8'h10, -1);
    idle(3);
    chk("t3_beats", mon_beats - b0, KB);
    drive(0, 0, 8'h00, 1, 0);
    chk("t3_ack", o_key_pending, 0);

    // 4: ack on the same cycle the timeout would fire
    drive(0, 0, 8'h00, 0, 1);
    frame(35, 8'h60, -1);
    guard = 0;
    while (!(m_pend && m_age == TO - 1) && guard < 200) begin
      idle(1);
      guard++;
    end
    chk("t4_wait", guard < 200, 1);
    drive(0, 0, 8'h00, 1, 0);
    idle(1);
    chk("t4_pend", o_key_pending, 0);
    chk("t4_tmo", o_timeout_cnt, 0);

    // random frames, gaps, acks and occasional clears
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(70, 1);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(3, 0) == 0)
          drive(0, 0, 8'($urandom), $urandom_range(15, 0) == 0,
                $urandom_range(199, 0) == 0);
        drive(1, i == len - 1, 8'($urandom),
              $urandom_range(15, 0) == 0,
              $urandom_range(199, 0) == 0);
      end
      repeat ($urandom_range(60, 0))
        drive(0, 0, 8'h00, $urandom_range(15, 0) == 0, 0);
    end
    idle(80);

    // 5: saturate the drop counter with back-to-back 1-beat frames
    drive(0, 0, 8'h00, 0, 1);
    guard = 0;
    while (e_drop < 65535 && guard < 80000) begin
      drive(1, 1, 8'($urandom), 0, 0);
      guard++;
    end
    chk("t5_sat", o_drop_cnt, 16'hFFFF);
    repeat (100) drive(1, 1, 8'($urandom), 0, 0);
    chk("t5_hold", o_drop_cnt, 16'hFFFF);
    guard = 0;
    while (!(m_pend || m_acc) && guard < 200) begin
      drive(1, 1, 8'($urandom), 0, 0);
      guard++;
    end
    drive(1, 1, 8'h5A, 0, 1);
    chk("t5_clr", o_drop_cnt, 0);
    idle(100);

    // 6: reset in the middle of a frame, then a fresh frame
    for (int i = 0; i < 10; i++) drive(1, 0, 8'(8'h20 + i), 0, 0);
    #2 i_rst = 1'b0;
    #1;
    chk("t6_vld", o_look_up_data_vld, 0);
    chk("t6_data", o_look_up_data, 0);
    chk("t6_cnt", o_look_up_data_cnt, 0);
    chk("t6_pend", o_key_pending, 0);
    chk("t6_drop", o_drop_cnt, 0);
    chk("t6_tmo", o_timeout_cnt, 0);
    @(posedge i_clk);
    #1;
    idle(3);
    i_rst = 1'b1;
    idle(1);
    b0 = mon_beats;
    frame(40, 8'h80, -1);
    idle(3);
    chk("t6_beats", mon_beats - b0, KB);
    chk("t6_pend1", o_key_pending, 1);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
